// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin encode arbiter.
//   N, IDXW     : requester count and encoded index width
//   IDLE, GRANT : FSM state encodings (legacy-compatible localparams)
//   rotr()      : rotate a request vector right by the round-robin pointer
package rr_arb_pkg;

  localparam int N    = 8;
  localparam int IDXW = 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Rotating right by ptr places requester ptr at bit 0, so a plain
  // lowest-index priority encoder then searches upward from ptr with wrap.
  function automatic logic [N-1:0] rotr(input logic [N-1:0] v,
                                        input logic [IDXW-1:0] s);
    logic [2*N-1:0] dbl;
    dbl = {v, v} >> s;
    return dbl[N-1:0];
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 lowest-index priority encoder.
//   req_in : 8-bit input vector
//   idx    : index of the lowest set bit (0 when none set)
//   any    : at least one bit of req_in is set
module prio_enc8
  import rr_arb_pkg::*;
(
  input  logic [N-1:0]    req_in,
  input  logic            unused_tie,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |req_in;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) idx = IDXW'(i);
    end
  end

  logic unused_ok;
  assign unused_ok = unused_tie;

endmodule

// File: rtl/rr_encode_arbiter.sv
// 8-requester round-robin arbiter with one-hot and encoded grant outputs.
// A grant is held until the owner pulses done, drops its request, or the
// hold limit MAX_HOLD expires (MAX_HOLD=0 disables the limit). One IDLE
// cycle always separates consecutive grants. CNTW must satisfy
// 2**CNTW > MAX_HOLD.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req     : request vector, bit i = requester i
//   done    : owner release pulse, only looked at while granting
//   gnt     : one-hot grant, zero when idle
//   gnt_idx : encoded owner index, zero when idle
//   gnt_vld : a grant is active
//   timeout : one-cycle pulse when the hold limit alone revoked a grant
module rr_encode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNTW     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);

  localparam logic [CNTW-1:0] LIMIT_CNT = CNTW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic            LIMIT_EN  = (MAX_HOLD != 0);

  logic [0:0]      state;
  logic [IDXW-1:0] ptr;
  logic [CNTW-1:0] hold_cnt;

  logic [N-1:0]    rot_req;
  logic [IDXW-1:0] rot_idx;
  logic            rot_any;
  logic [IDXW-1:0] winner;

  logic            owner_req;
  logic            limit_hit;
  logic            rel;
  logic            limit_only;

  assign rot_req = rotr(req, ptr);

  prio_enc8 u_enc (
    .req_in     (rot_req),
    .unused_tie (1'b0),
    .idx        (rot_idx),
    .any        (rot_any)
  );

  // Undo the rotation; the 3-bit add wraps modulo 8 on its own.
  assign winner = rot_idx + ptr;

  // Release decode for the current owner. The timeout pulse is reserved
  // for the case where the limit is the only reason the grant ends.
  always_comb begin
    owner_req  = req[gnt_idx];
    limit_hit  = LIMIT_EN && (hold_cnt == LIMIT_CNT);
    rel        = done || !owner_req || limit_hit;
    limit_only = limit_hit && !done && owner_req;
  end

  // FSM, pointer, hold counter and registered outputs. Requests from other
  // agents are not looked at while granting, so ownership only changes by
  // way of IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (rot_any) begin
          state    <= GRANT;
          gnt      <= N'(1) << winner;
          gnt_idx  <= winner;
          gnt_vld  <= 1'b1;
          hold_cnt <= '0;
        end
      end else begin
        if (rel) begin
          state    <= IDLE;
          gnt      <= '0;
          gnt_idx  <= '0;
          gnt_vld  <= 1'b0;
          ptr      <= gnt_idx + IDXW'(1);
          timeout  <= limit_only;
        end else if (hold_cnt != {CNTW{1'b1}}) begin
          hold_cnt <= hold_cnt + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: doc/rr_encode_arbiter.md
Name: rr_encode_arbiter

Overview:
- 8-requester round-robin arbiter that shares one downstream resource, such as an 8-to-3 encoded select bus.
- Outputs the winner both one-hot and as a 3-bit encoded index.
- Holds each grant until the owner releases it, drops its request, or a hold timeout expires.
- Sits between requesting agents and the shared datapath it sequences.

Parameters:
- N, 8, number of requesters; fixed at 8 for this revision.
- IDXW, 3, width of the encoded grant index (log2 N).
- MAX_HOLD, 15, maximum number of cycles a grant may be held; 0 disables the timeout.
- CNTW, 4, hold-counter width; must satisfy 2^CNTW > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit i = requester i.
- done  input  1  owner release pulse; sampled only in GRANT.
- gnt  output  N  one-hot grant; all zeros when idle.
- gnt_idx  output  IDXW  encoded index of the owner; 0 when idle.
- gnt_vld  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - Reset mid-grant drops the grant the same instant; no release or timeout pulse is produced.
- All outputs are registered.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0 at a rising edge, the winner is the first set bit searching upward from ptr, wrapping 7->0.
  - Next cycle: state=GRANT, gnt=1<<w, gnt_idx=w, gnt_vld=1, hold_cnt=0.
  - If req==0, stay in IDLE.
  - done is ignored in IDLE.
- Latency: req sampled at edge k -> gnt_vld high after edge k.
- Winner search:
  - Rotate req right by ptr.
  - Priority-encode the lowest set bit.
  - Add ptr modulo 8; 3-bit wrap-around is natural.
- GRANT, each edge, with owner o:
  - Release condition: done=1, OR req[o]=0, OR (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
  - On release:
    - state=IDLE; gnt, gnt_idx, gnt_vld cleared next cycle.
    - ptr=(o+1) mod 8.
    - timeout=1 for one cycle only if the hold limit was the sole cause.
  - Otherwise hold_cnt increments; it saturates and never wraps.
- Simultaneous release causes (done plus req drop plus limit in the same cycle): a single release occurs, and timeout=0.
- There is always exactly one IDLE bubble cycle between consecutive grants.
  - Fairness: a requester held continuously waits at most 7 grants.
- Requests from non-owners during GRANT have no effect until IDLE.
- A grant never changes owner without passing through IDLE.
- Invariants (checked by assertions):
  - gnt is one-hot or zero.
  - gnt_vld == |gnt.
  - gnt_idx encodes gnt.

Decomposition:
- Package rr_arb_pkg holds:
  - N, IDXW.
  - State enum {IDLE, GRANT}.
  - A function for rotate-by-ptr.
- Sub-module prio_enc8: combinational 8-to-3 lowest-index priority encoder with outputs idx[2:0] and any.
  - Instantiated once, on the rotated request vector.
- Top-level contents: FSM, ptr register, hold counter, output registers.

Test Plan:
- Reset then req=8'b0000_0100 -> after one edge gnt=8'b0000_0100, gnt_idx=2, gnt_vld=1. Then done=1 for one cycle -> gnt=0 next cycle, ptr=3.
- Rotation: req=8'hFF held, done pulsed each grant -> gnt_idx sequence 0,1,2,...,7,0, with one idle cycle between grants.
- Wrap search: ptr=6 via prior grant to 5, then req=8'b0010_0001 -> gnt_idx=0 (6,7 empty, wraps to 0), not 5.
- Timeout: MAX_HOLD=15, req=8'b0000_1000 held, no done -> grant lasts exactly 15 cycles, timeout=1 for one cycle at release, then regranted to 3 after the IDLE cycle.
- Simultaneous release: done=1 and req[o] drop on the last hold cycle -> single release, timeout=0, ptr=o+1.
- Reset mid-grant: assert rst_n=0 while gnt_idx=4 -> all outputs 0 immediately with no clock needed. After release of reset, req=8'b0001_0000 -> granted starting from ptr=0, gnt_idx=4.
